// File: rtl/adder_arb_pkg.sv
// rtl/adder_arb_pkg.sv - shared types and round-robin pick helper for adder_arbiter
package adder_arb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      OUT  = 2'd2
   } state_t;

   localparam int MAX_REQ = 32;
   localparam int IDX_W   = 5;

   typedef struct packed {
      logic             found;
      logic [IDX_W-1:0] idx;
   } rr_pick_t;

   // First set bit of req scanning ptr, ptr+1, ... wrapping at nreq.
   function automatic rr_pick_t rr_next(input logic [MAX_REQ-1:0] req,
                                        input logic [IDX_W-1:0]   ptr,
                                        input int                 nreq);
      rr_pick_t p;
      int       j;
      p = '0;
      for (int i = 0; i < MAX_REQ; i++) begin
         j = int'(ptr) + i;
         if (j >= nreq) j = j - nreq;
         if (i < nreq && !p.found && req[j[IDX_W-1:0]]) begin
            p.found = 1'b1;
            p.idx   = j[IDX_W-1:0];
         end
      end
      return p;
   endfunction

endpackage

// File: rtl/adder_arbiter_add.sv
// rtl/adder_arbiter_add.sv - shared combinational adder datapath
module adder_arbiter_add #(
   parameter int W = 9
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   output logic [W-1:0] sum
);

   assign sum = a + b;

endmodule

// File: rtl/adder_arbiter.sv
// rtl/adder_arbiter.sv - round-robin arbiter sequencing NREQ clients onto one adder
module adder_arbiter
   import adder_arb_pkg::*;
#(
   parameter  int WIDTH = 8,
   parameter  int NREQ  = 4,
   localparam int IDW   = $clog2(NREQ)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [NREQ-1:0]       req,
   input  logic [NREQ*WIDTH-1:0] op_a,
   input  logic [NREQ*WIDTH-1:0] op_b,
   output logic [NREQ-1:0]       gnt,
   output logic                  res_valid,
   input  logic                  res_ready,
   output logic [WIDTH-1:0]      res_sum,
   output logic                  res_cout,
   output logic [IDW-1:0]        res_id,
   output logic                  busy
);

   state_t               state_q, state_d;
   logic [IDW-1:0]       ptr_q;
   logic [WIDTH-1:0]     a_q, b_q;
   logic [IDW-1:0]       id_q;
   logic [WIDTH:0]       sum_full;
   logic [MAX_REQ-1:0]   req_ext;
   rr_pick_t             pick;
   logic [IDW-1:0]       win;

   always_comb begin
      req_ext             = '0;
      req_ext[NREQ-1:0]   = req;
      pick                = rr_next(req_ext, IDX_W'(ptr_q), NREQ);
      win                 = IDW'(pick.idx);
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (pick.found) state_d = CALC;
         CALC:    state_d = OUT;
         OUT:     if (res_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Only the winner's operand slice is read, so X elsewhere never reaches the adder.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         gnt       <= '0;
         ptr_q     <= '0;
         a_q       <= '0;
         b_q       <= '0;
         id_q      <= '0;
         res_valid <= 1'b0;
         res_sum   <= '0;
         res_cout  <= 1'b0;
         res_id    <= '0;
      end else begin
         gnt <= '0;
         if (state_q == IDLE && pick.found) begin
            a_q   <= op_a[win*WIDTH +: WIDTH];
            b_q   <= op_b[win*WIDTH +: WIDTH];
            id_q  <= win;
            gnt   <= NREQ'(1) << win;
            ptr_q <= (win == IDW'(NREQ-1)) ? '0 : win + 1'b1;
         end
         if (state_q == CALC) begin
            res_sum   <= sum_full[WIDTH-1:0];
            res_cout  <= sum_full[WIDTH];
            res_id    <= id_q;
            res_valid <= 1'b1;
         end
         if (state_q == OUT && res_ready) begin
            res_valid <= 1'b0;
         end
      end
   end

   adder_arbiter_add #(
      .W (WIDTH + 1)
   ) u_add (
      .a   ({1'b0, a_q}),
      .b   ({1'b0, b_q}),
      .sum (sum_full)
   );

   assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_adder_arbiter.sv
// tb/tb_adder_arbiter.sv - self-checking bench for adder_arbiter
module tb_adder_arbiter;

   localparam int W = 8;
   localparam int N = 4;

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic [N-1:0]     req;
   logic [N*W-1:0]   op_a, op_b;
   logic [N-1:0]     gnt;
   logic             res_valid, res_ready, res_cout, busy;
   logic [W-1:0]     res_sum;
   logic [1:0]       res_id;

   logic [2:0]       req3, gnt3;
   logic [3*W-1:0]   op_a3, op_b3;
   logic             res_valid3, res_ready3, res_cout3, busy3;
   logic [W-1:0]     res_sum3;
   logic [1:0]       res_id3;

   int cyc = 0;
   int tests = 0;
   int fails = 0;
   int ptr_m = 0;
   int gnt_cyc = 0;
   int cons_cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   adder_arbiter #(.WIDTH(W), .NREQ(N)) dut (
      .clk(clk), .rst_n(rst_n), .req(req), .op_a(op_a), .op_b(op_b),
      .gnt(gnt), .res_valid(res_valid), .res_ready(res_ready),
      .res_sum(res_sum), .res_cout(res_cout), .res_id(res_id), .busy(busy)
   );

   adder_arbiter #(.WIDTH(W), .NREQ(3)) dut3 (
      .clk(clk), .rst_n(rst_n), .req(req3), .op_a(op_a3), .op_b(op_b3),
      .gnt(gnt3), .res_valid(res_valid3), .res_ready(res_ready3),
      .res_sum(res_sum3), .res_cout(res_cout3), .res_id(res_id3), .busy(busy3)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Round-robin rule: nearest requesting index at or after p, modulo N.
   function automatic int pick(input int p, input logic [N-1:0] r);
      for (int k = 0; k < N; k++)
         if (r[(p + k) % N]) return (p + k) % N;
      return 0;
   endfunction

   task automatic set_slice(input int i, input bit rnd);
      if (rnd) begin
         op_a[i*W +: W] = W'($urandom());
         op_b[i*W +: W] = W'($urandom());
      end else begin
         op_a[i*W +: W] = 'x;
         op_b[i*W +: W] = 'x;
      end
   endtask

   task automatic do_op(input string tag, input bit reraise, input int hold,
                        input logic [N-1:0] add_req);
      int           w;
      int           s;
      logic [N-1:0] exp_g;
      w     = pick(ptr_m, req);
      exp_g = N'(1) << w;
      s     = int'(op_a[w*W +: W]) + int'(op_b[w*W +: W]);
      res_ready = (hold == 0);
      for (int i = 0; i < 20; i++) begin
         @(posedge clk); #1;
         if (gnt != 0) break;
      end
      gnt_cyc = cyc;
      check({tag, "_gnt"}, 32'(gnt), 32'(exp_g));
      check({tag, "_busy"}, 32'(busy), 32'd1);
      ptr_m = (w + 1) % N;
      @(negedge clk);
      req[w] = 1'b0;
      set_slice(w, reraise);
      for (int i = 0; i < N; i++) if (add_req[i]) set_slice(i, 1'b1);
      req = req | add_req;
      @(posedge clk); #1;
      check({tag, "_gnt_drop"}, 32'(gnt), 32'd0);
      check({tag, "_valid"}, 32'(res_valid), 32'd1);
      check({tag, "_sum"}, 32'(res_sum), s % 256);
      check({tag, "_cout"}, 32'(res_cout), 32'(s >= 256));
      check({tag, "_id"}, 32'(res_id), w);
      if (reraise) begin
         @(negedge clk);
         req[w] = 1'b1;
      end
      for (int i = 0; i < hold; i++) begin
         @(posedge clk); #1;
         check({tag, "_hold_valid"}, 32'(res_valid), 32'd1);
         check({tag, "_hold_sum"}, 32'(res_sum), s % 256);
         check({tag, "_hold_gnt"}, 32'(gnt), 32'd0);
      end
      if (hold > 0) begin
         @(negedge clk);
         res_ready = 1'b1;
      end
      @(posedge clk); #1;
      cons_cyc = cyc;
      check({tag, "_consumed"}, 32'(res_valid), 32'd0);
      check({tag, "_sum_kept"}, 32'(res_sum), s % 256);
   endtask

   initial begin
      int prev;
      int c;
      int mask;
      logic [N-1:0] nw;
      int s3;
      req = '0; op_a = '0; op_b = '0; res_ready = 1'b1;
      req3 = '0; op_a3 = '0; op_b3 = '0; res_ready3 = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check("rst_gnt", 32'(gnt), 32'd0);
      check("rst_valid", 32'(res_valid), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_sum", 32'(res_sum), 32'd0);
      check("rst_cout", 32'(res_cout), 32'd0);
      check("rst_id", 32'(res_id), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      // single requester, simple sum
      op_a[2*W +: W] = 8'h0F; op_b[2*W +: W] = 8'h01; req = 4'b0100;
      do_op("t1", 1'b0, 0, '0);
      check("t1_sum_lit", 32'(res_sum), 32'h10);

      // carry-out cases
      @(negedge clk);
      op_a[W-1:0] = 8'hFF; op_b[W-1:0] = 8'h01; req = 4'b0001;
      do_op("t2a", 1'b0, 0, '0);
      check("t2a_cout_lit", 32'(res_cout), 32'd1);
      @(negedge clk);
      op_a[W-1:0] = 8'h80; op_b[W-1:0] = 8'h80; req = 4'b0001;
      do_op("t2b", 1'b0, 0, '0);
      check("t2b_sum_lit", 32'(res_sum), 32'd0);

      // all requesting: rotation with 3-cycle grant spacing
      @(negedge clk);
      for (int i = 0; i < N; i++) set_slice(i, 1'b1);
      req = 4'hF;
      prev = 0;
      for (int k = 0; k < 6; k++) begin
         do_op("t3", k < 5, 0, '0);
         if (k > 0) check("t3_spacing", gnt_cyc - prev, 32'd3);
         prev = gnt_cyc;
      end
      req = '0;

      // backpressure with a pending requester
      @(negedge clk);
      set_slice(0, 1'b1); req = 4'b0001;
      do_op("t4a", 1'b0, 5, 4'b0010);
      c = cons_cyc;
      do_op("t4b", 1'b0, 0, '0);
      check("t4_next_grant", gnt_cyc - c, 32'd1);

      // randomized traffic, unrequested slices driven X
      for (int it = 0; it < 10; it++) begin
         mask = $urandom_range(1, 15);
         nw = N'(mask) & ~req;
         for (int i = 0; i < N; i++) if (nw[i]) set_slice(i, 1'b1);
         req = req | nw;
         do_op("rnd", 1'b0, $urandom_range(0, 2), '0);
      end
      req = '0;
      for (int i = 0; i < N; i++) set_slice(i, 1'b0);

      // reset in the middle of an operation
      @(negedge clk);
      set_slice(2, 1'b1); req = 4'b0100;
      @(posedge clk); #1;
      check("t5_gnt", 32'(gnt), 32'h4);
      #2;
      rst_n = 1'b0; req = '0;
      #1;
      check("t5_rst_gnt", 32'(gnt), 32'd0);
      check("t5_rst_busy", 32'(busy), 32'd0);
      check("t5_rst_valid", 32'(res_valid), 32'd0);
      check("t5_rst_sum", 32'(res_sum), 32'd0);
      check("t5_rst_id", 32'(res_id), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      ptr_m = 0;
      repeat (4) begin
         @(posedge clk); #1;
         check("t5_no_result", 32'(res_valid), 32'd0);
      end
      @(negedge clk);
      set_slice(0, 1'b1); set_slice(3, 1'b1); req = 4'b1001;
      do_op("t5a", 1'b0, 0, '0);
      check("t5a_id_lit", 32'(res_id), 32'd0);
      do_op("t5b", 1'b0, 0, '0);
      check("t5b_id_lit", 32'(res_id), 32'd3);
      req = '0;

      // three requesters: wrap from index 2 to 0
      @(negedge clk);
      op_a3 = 24'($urandom()); op_b3 = 24'($urandom()); req3 = 3'b010;
      @(posedge clk); #1;
      check("t6_gnt1", 32'(gnt3), 32'h2);
      @(negedge clk); req3 = '0;
      @(posedge clk); #1;
      check("t6_id1", 32'(res_id3), 32'd1);
      @(posedge clk);
      @(negedge clk); req3 = 3'b101;
      @(posedge clk); #1;
      check("t6_gnt2", 32'(gnt3), 32'h4);
      s3 = int'(op_a3[2*W +: W]) + int'(op_b3[2*W +: W]);
      @(negedge clk); req3 = 3'b001;
      @(posedge clk); #1;
      check("t6_id2", 32'(res_id3), 32'd2);
      check("t6_sum2", 32'(res_sum3), s3 % 256);
      check("t6_cout2", 32'(res_cout3), 32'(s3 >= 256));
      @(posedge clk);
      @(posedge clk); #1;
      check("t6_gnt0", 32'(gnt3), 32'h1);
      @(negedge clk); req3 = '0;
      @(posedge clk); #1;
      check("t6_id0", 32'(res_id3), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
